// File: rtl/alu_seq.sv
// alu_seq: clocked execute-stage ALU.
//   Single-cycle ops (move, add/sub, logic, shifts, LUI, HI/LO read) finish in
//   IDLE on the start edge. Multiply and divide iterate one bit per clock over
//   WIDTH clocks into internal HI/LO registers, then apply the sign fix-up in
//   the FIX cycle.
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   start             issue operation (ignored while busy)
//   operation[3:0]    opcode; sign[1]=signed, sign[0]=subtract (add/sub only)
//   A, B              operands, captured on the start edge
//   Y                 registered single-cycle result
//   outHI, outLO      HI/LO registers (remainder/quotient or product halves)
//   carryFlag[3:0]    {C,Z,N,V}, written only by add/sub
//   busy              multiply/divide in progress
//   done              one-cycle pulse when results are valid
module alu_seq #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [1:0]       sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] outHI,
    output logic [WIDTH-1:0] outLO,
    output logic [3:0]       carryFlag,
    output logic             busy,
    output logic             done
);
    localparam logic [3:0] OP_MOV = 4'b0000, OP_ADD = 4'b0001, OP_MUL = 4'b0010,
                           OP_DIV = 4'b0011, OP_AND = 4'b0100, OP_OR  = 4'b0101,
                           OP_NOR = 4'b0110, OP_SRL = 4'b0111, OP_SLL = 4'b1000,
                           OP_SRA = 4'b1001, OP_LUI = 4'b1010, OP_MFH = 4'b1011,
                           OP_MFL = 4'b1100;
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t                 r_state, w_state_nxt;
    logic [SHW-1:0]         r_cnt;
    logic [WIDTH-1:0]       r_y, r_hi, r_lo, r_a;
    logic [3:0]             r_flags;
    logic                   r_done;
    // Iteration registers: product hi/lo during multiply, remainder/quotient
    // during divide. r_opnd is the multiplicand or the divisor magnitude.
    logic [WIDTH-1:0]       r_acc_hi, r_acc_lo, r_opnd;
    logic                   r_is_div, r_negq, r_negr, r_dz;

    logic                   w_is_md, w_busy;
    logic [WIDTH-1:0]       w_bx, w_amag, w_bmag;
    logic [WIDTH:0]         w_sum, w_mstep, w_dtrial;
    logic                   w_ovf;
    logic [2*WIDTH-1:0]     w_prod, w_prod_fix;

    assign w_is_md = (operation == OP_MUL) || (operation == OP_DIV);

    // Add/sub: subtract is A + ~B + 1, so C=1 means "no borrow".
    assign w_bx    = sign[0] ? ~B : B;
    assign w_sum   = {1'b0, A} + {1'b0, w_bx} + {{WIDTH{1'b0}}, sign[0]};
    assign w_ovf   = (A[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);

    // Iterate on magnitudes; signs are restored in FIX.
    assign w_amag  = (sign[1] && A[WIDTH-1]) ? -A : A;
    assign w_bmag  = (sign[1] && B[WIDTH-1]) ? -B : B;

    // Shift-add step: add multiplicand when the current multiplier bit is set,
    // then shift the whole {hi,lo} pair right by one.
    assign w_mstep  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
    // Restoring step: bring in the next dividend bit and try a subtract;
    // bit WIDTH set means the trial went negative.
    assign w_dtrial = {r_acc_hi, r_acc_lo[WIDTH-1]} - {1'b0, r_opnd};

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_negq ? -w_prod : w_prod;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start && w_is_md) w_state_nxt = S_RUN;
            end
            S_RUN:   if (r_cnt == LAST) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_y      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_a      <= '0;
            r_flags  <= '0;
            r_done   <= 1'b0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_negq   <= 1'b0;
            r_negr   <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_done <= !w_is_md;
                    case (operation)
                        OP_MOV: r_y <= B;
                        OP_ADD: begin
                            r_y     <= w_sum[WIDTH-1:0];
                            r_flags <= {w_sum[WIDTH], (w_sum[WIDTH-1:0] == '0),
                                        w_sum[WIDTH-1], sign[1] & w_ovf};
                        end
                        OP_MUL: begin
                            r_acc_hi <= '0;
                            r_acc_lo <= w_bmag;
                            r_opnd   <= w_amag;
                            r_is_div <= 1'b0;
                            r_negq   <= sign[1] & (A[WIDTH-1] ^ B[WIDTH-1]);
                            r_negr   <= 1'b0;
                            r_dz     <= 1'b0;
                            r_cnt    <= '0;
                        end
                        OP_DIV: begin
                            r_acc_hi <= '0;
                            r_acc_lo <= w_amag;
                            r_opnd   <= w_bmag;
                            r_is_div <= 1'b1;
                            r_negq   <= sign[1] & (A[WIDTH-1] ^ B[WIDTH-1]);
                            r_negr   <= sign[1] & A[WIDTH-1];
                            r_dz     <= (B == '0);
                            r_a      <= A;
                            r_cnt    <= '0;
                        end
                        OP_AND: r_y <= A & B;
                        OP_OR:  r_y <= A | B;
                        OP_NOR: r_y <= ~(A | B);
                        OP_SRL: r_y <= B >> A[SHW-1:0];
                        OP_SLL: r_y <= B << A[SHW-1:0];
                        OP_SRA: r_y <= $signed(B) >>> A[SHW-1:0];
                        OP_LUI: r_y <= {A[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
                        OP_MFH: r_y <= r_hi;
                        OP_MFL: r_y <= r_lo;
                        default: ;  // no-op: only done pulses
                    endcase
                end
                S_RUN: begin
                    r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + SHW'(1);
                    if (r_is_div) begin
                        if (!w_dtrial[WIDTH]) begin
                            r_acc_hi <= w_dtrial[WIDTH-1:0];
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_acc_hi <= {r_acc_hi[WIDTH-2:0], r_acc_lo[WIDTH-1]};
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_acc_hi <= w_mstep[WIDTH:1];
                        r_acc_lo <= {w_mstep[0], r_acc_lo[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (!r_is_div) begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end else if (r_dz) begin
                        // Divide by zero: fixed pattern, dividend passed to HI.
                        r_hi <= r_a;
                        r_lo <= '1;
                    end else begin
                        r_hi <= r_negr ? -r_acc_hi : r_acc_hi;
                        r_lo <= r_negq ? -r_acc_lo : r_acc_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Y         = r_y;
    assign outHI     = r_hi;
    assign outLO     = r_lo;
    assign carryFlag = r_flags;
    assign busy      = w_busy;
    assign done      = r_done;
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [3:0]   operation = '0;
    logic [1:0]   sign = '0;
    logic [W-1:0] A = '0, B = '0;
    logic [W-1:0] Y, outHI, outLO;
    logic [3:0]   carryFlag;
    logic         busy, done;

    logic         start8 = 1'b0;
    logic [3:0]   op8 = '0;
    logic [1:0]   sg8 = '0;
    logic [7:0]   a8 = '0, b8 = '0;
    logic [7:0]   y8, hi8, lo8;
    logic [3:0]   fl8;
    logic         busy8, done8;

    int n_tests = 0, n_fail = 0;

    // Reference state
    logic [W-1:0] m_y = '0, m_hi = '0, m_lo = '0;
    logic [3:0]   m_fl = '0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .operation(operation), .sign(sign),
        .A(A), .B(B), .Y(Y), .outHI(outHI), .outLO(outLO), .carryFlag(carryFlag),
        .busy(busy), .done(done)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .operation(op8), .sign(sg8),
        .A(a8), .B(b8), .Y(y8), .outHI(hi8), .outLO(lo8), .carryFlag(fl8),
        .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: arithmetic on wide integers, straight from the opcode table.
    task automatic model(input logic [3:0] op, input logic [1:0] sg,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        longint     r, q;
        logic [63:0] p;
        case (op)
            4'd0:  m_y = b;
            4'd1: begin
                if (sg[0]) begin
                    m_y   = a - b;
                    m_fl[3] = (a >= b);
                    r     = longint'($signed(a)) - longint'($signed(b));
                end else begin
                    m_y   = a + b;
                    m_fl[3] = ((64'(a) + 64'(b)) >= 64'h1_0000_0000);
                    r     = longint'($signed(a)) + longint'($signed(b));
                end
                m_fl[2] = (m_y == 0);
                m_fl[1] = m_y[W-1];
                m_fl[0] = sg[1] && (r > 64'sd2147483647 || r < -64'sd2147483648);
            end
            4'd2: begin
                if (sg[1]) p = longint'($signed(a)) * longint'($signed(b));
                else       p = 64'(a) * 64'(b);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            4'd3: begin
                if (b == 0) begin
                    m_lo = '1;
                    m_hi = a;
                end else if (sg[1]) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            4'd4:  m_y = a & b;
            4'd5:  m_y = a | b;
            4'd6:  m_y = ~(a | b);
            4'd7:  m_y = b >> a[4:0];
            4'd8:  m_y = b << a[4:0];
            4'd9:  m_y = W'($signed(b) >>> a[4:0]);
            4'd10: m_y = {a[15:0], 16'h0000};
            4'd11: m_y = m_hi;
            4'd12: m_y = m_lo;
            default: ;
        endcase
    endtask

    // Issue one operation and check it. poke re-drives start/A/B mid-run.
    task automatic do_op(input logic [3:0] op, input logic [1:0] sg,
                         input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        int n;
        bit bad_busy;
        @(negedge clk);
        operation = op; sign = sg; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model(op, sg, a, b);
        if (op == 4'd2 || op == 4'd3) begin
            chk($sformatf("busy_t0 op%0d", op), 64'(busy), 64'(1));
            n = 0; bad_busy = 0;
            while (!done && n < 100) begin
                @(negedge clk);
                if (poke && n >= 3 && n < 8) begin
                    start = 1'b1; A = $urandom; B = $urandom; operation = 4'd3;
                end else start = 1'b0;
                @(posedge clk); #1;
                n++;
                if (!done && !busy) bad_busy = 1;
            end
            start = 1'b0;
            chk($sformatf("latency op%0d", op), 64'(n), 64'(W + 1));
            chk($sformatf("busy_run op%0d", op), 64'(bad_busy), 64'(0));
            chk($sformatf("busy_end op%0d", op), 64'(busy), 64'(0));
            chk($sformatf("HI op%0d a=%0h b=%0h", op, a, b), 64'(outHI), 64'(m_hi));
            chk($sformatf("LO op%0d a=%0h b=%0h", op, a, b), 64'(outLO), 64'(m_lo));
            chk($sformatf("Y_hold op%0d", op), 64'(Y), 64'(m_y));
        end else begin
            chk($sformatf("done op%0d", op), 64'(done), 64'(1));
            chk($sformatf("busy op%0d", op), 64'(busy), 64'(0));
            chk($sformatf("Y op%0d a=%0h b=%0h", op, a, b), 64'(Y), 64'(m_y));
            chk($sformatf("flags op%0d", op), 64'(carryFlag), 64'(m_fl));
            chk($sformatf("HILO_hold op%0d", op), {outHI, outLO}, {m_hi, m_lo});
        end
    endtask

    initial begin
        int n;
        bit saw_done;
        logic [3:0]  rop;
        logic [15:0] p8;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst Y", 64'(Y), 64'(0));
        chk("rst HILO", {outHI, outLO}, 64'(0));
        chk("rst flags", 64'(carryFlag), 64'(0));
        chk("rst busy/done", 64'({busy, done}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        do_op(4'd1, 2'b10, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        chk("sadd flags", 64'(carryFlag), 64'(4'b0011));
        do_op(4'd1, 2'b01, 32'h5, 32'h5, 0);
        chk("usub flags", 64'(carryFlag), 64'(4'b1100));
        do_op(4'd4, 2'b00, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        do_op(4'd2, 2'b10, 32'hFFFF_FFFD, 32'h0000_0005, 0);
        chk("smul HI", 64'(outHI), 64'(32'hFFFF_FFFF));
        chk("smul LO", 64'(outLO), 64'(32'hFFFF_FFF1));
        do_op(4'd12, 2'b00, 32'h0, 32'h0, 0);
        chk("mflo", 64'(Y), 64'(32'hFFFF_FFF1));
        do_op(4'd3, 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        chk("sdiv LO", 64'(outLO), 64'(32'hFFFF_FFFD));
        chk("sdiv HI", 64'(outHI), 64'(32'hFFFF_FFFF));
        do_op(4'd3, 2'b00, 32'h64, 32'h0, 0);
        chk("div0 LO", 64'(outLO), 64'(32'hFFFF_FFFF));
        chk("div0 HI", 64'(outHI), 64'(32'h64));
        do_op(4'd3, 2'b10, 32'hFFFF_FFF9, 32'h0, 0);
        do_op(4'd11, 2'b00, 32'h0, 32'h0, 0);
        do_op(4'd3, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(4'd2, 2'b00, 32'h0000_FFFF, 32'h0000_FFFF, 1);
        chk("umul HI", 64'(outHI), 64'(0));
        chk("umul LO", 64'(outLO), 64'(32'hFFFE_0001));
        do_op(4'd9, 2'b00, 32'h0000_0024, 32'h8000_0000, 0);
        chk("sra", 64'(Y), 64'(32'hF800_0000));
        do_op(4'd10, 2'b00, 32'h0000_1234, 32'h0, 0);
        chk("lui", 64'(Y), 64'(32'h1234_0000));
        do_op(4'd14, 2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 0);

        // Reset in the middle of a multiply
        @(negedge clk);
        operation = 4'd2; sign = 2'b00; A = 32'h1234_5678; B = 32'h9ABC_DEF0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst busy", 64'(busy), 64'(0));
        chk("midrst HILO", {outHI, outLO}, 64'(0));
        chk("midrst Y", 64'(Y), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        m_y = '0; m_hi = '0; m_lo = '0; m_fl = '0;
        saw_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done = 1;
        end
        chk("midrst no done", 64'(saw_done), 64'(0));

        // Randomized sequence
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] ra, rb;
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
            do_op(rop, 2'($urandom_range(0, 3)), ra, rb, 0);
        end

        // Narrow instance: signed -3 x 5
        @(negedge clk);
        op8 = 4'd2; sg8 = 2'b10; a8 = 8'hFD; b8 = 8'h05; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        p8 = 16'(int'($signed(a8)) * int'($signed(b8)));
        chk("w8 latency", 64'(n), 64'(9));
        chk("w8 HI", 64'(hi8), 64'(p8[15:8]));
        chk("w8 LO", 64'(lo8), 64'(p8[7:0]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
